// File: rtl/rx_sync_deframer.sv
// Symbol-level sync hunter and payload byte packer for BPSK/QPSK/8PSK hard decisions.
// Tolerates sync bit errors and 180-degree inversion; bytes leave through a registered FWFT FIFO.
module rx_sync_deframer #(
  parameter logic [31:0] SYNC_WORD  = 32'h1ACFFC1D,
  parameter int unsigned SYNC_LEN   = 32,
  parameter int unsigned MAX_ERR    = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk_32M768,
  input  logic       rst_32M768,
  input  logic       sym_tvalid,
  input  logic [2:0] sym_tdata,
  input  logic [1:0] MODE_CTRL,
  input  logic [7:0] PAYLOAD_LEN,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       lock,
  output logic       overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam int unsigned         AW       = $clog2(FIFO_DEPTH);
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [5:0]          ERR_LO   = 6'(MAX_ERR);
  localparam logic [5:0]          ERR_HI   = 6'(SYNC_LEN - MAX_ERR);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(FIFO_DEPTH);

  function automatic logic [5:0] f_popcnt(input logic [SYNC_LEN-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < SYNC_LEN; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic [1:0]          r_state;
  logic [SYNC_LEN-1:0] r_shift;
  logic                r_chk;
  logic [1:0]          r_mode;
  logic                r_inv;
  logic [8:0]          r_bcnt;
  logic [9:0]          r_acc;
  logic [3:0]          r_fill;
  logic                r_byte_vld;
  logic [7:0]          r_byte;
  logic                r_byte_last;
  logic                r_byte_user;
  logic [9:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_cnt;
  logic                r_ovld;
  logic [7:0]          r_tdata;
  logic                r_tlast;
  logic                r_tuser;
  logic                r_overflow;

  logic [1:0]          w_mode;
  logic [1:0]          w_k;
  logic [2:0]          w_pbits;
  logic [SYNC_LEN-1:0] w_shift_next;
  logic [9:0]          w_acc_app;
  logic [3:0]          w_fill_app;
  logic [7:0]          w_byte;
  logic [5:0]          w_dist;
  logic                w_match_n;
  logic                w_match_i;
  logic [AW:0]         w_total;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                w_ld;

  // Async assert, release aligned to the clock through two flops.
  always_ff @(posedge clk_32M768 or negedge rst_32M768) begin
    if (!rst_32M768) r_rst_sync <= '0;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_mode  = (r_state == ST_PAYLOAD) ? r_mode : MODE_CTRL;
  assign w_pbits = sym_tdata ^ {3{r_inv}};

  always_comb begin
    w_k          = 2'd0;
    w_shift_next = r_shift;
    w_acc_app    = r_acc;
    case (w_mode)
      2'd0: begin
        w_k          = 2'd1;
        w_shift_next = {r_shift[SYNC_LEN-2:0], sym_tdata[0]};
        w_acc_app    = {r_acc[8:0], w_pbits[0]};
      end
      2'd1: begin
        w_k          = 2'd2;
        w_shift_next = {r_shift[SYNC_LEN-3:0], sym_tdata[1:0]};
        w_acc_app    = {r_acc[7:0], w_pbits[1:0]};
      end
      2'd2: begin
        w_k          = 2'd3;
        w_shift_next = {r_shift[SYNC_LEN-4:0], sym_tdata[2:0]};
        w_acc_app    = {r_acc[6:0], w_pbits[2:0]};
      end
      default: ;
    endcase
  end

  // Valid bits sit right-aligned in r_acc; the byte is the top 8 of them.
  assign w_fill_app = r_fill + {2'b00, w_k};
  assign w_byte     = 8'(w_acc_app >> (w_fill_app - 4'd8));

  assign w_dist    = f_popcnt(r_shift ^ SYNC_PAT);
  assign w_match_n = (w_dist <= ERR_LO);
  assign w_match_i = (w_dist >= ERR_HI) && ((MODE_CTRL == 2'd0) || (MODE_CTRL == 2'd1));

  always_ff @(posedge clk_32M768 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_HUNT;
      r_shift     <= '0;
      r_chk       <= 1'b0;
      r_mode      <= '0;
      r_inv       <= 1'b0;
      r_bcnt      <= '0;
      r_acc       <= '0;
      r_fill      <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_byte_last <= 1'b0;
      r_byte_user <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_chk      <= sym_tvalid && (r_state == ST_HUNT);
      if (sym_tvalid && (w_k != 2'd0)) r_shift <= w_shift_next;
      case (r_state)
        ST_IDLE: begin
          if (MODE_CTRL != 2'd3) r_state <= ST_HUNT;
        end
        ST_HUNT: begin
          if (MODE_CTRL == 2'd3) begin
            r_state <= ST_IDLE;
          end else if (r_chk && (w_match_n || w_match_i)) begin
            r_state <= ST_PAYLOAD;
            r_mode  <= MODE_CTRL;
            r_inv   <= ~w_match_n;
            r_bcnt  <= (PAYLOAD_LEN == 8'd0) ? 9'd256 : {1'b0, PAYLOAD_LEN};
            r_acc   <= '0;
            r_fill  <= '0;
            r_shift <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (sym_tvalid) begin
            if (w_fill_app >= 4'd8) begin
              r_byte_vld  <= 1'b1;
              r_byte      <= w_byte;
              r_byte_user <= r_inv;
              if (r_bcnt == 9'd1) begin
                r_byte_last <= 1'b1;
                r_acc       <= '0;
                r_fill      <= '0;
                r_state     <= (MODE_CTRL == 2'd3) ? ST_IDLE : ST_HUNT;
              end else begin
                r_byte_last <= 1'b0;
                r_bcnt      <= r_bcnt - 9'd1;
                r_acc       <= w_acc_app;
                r_fill      <= w_fill_app - 4'd8;
              end
            end else begin
              r_acc  <= w_acc_app;
              r_fill <= w_fill_app;
            end
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  // Capacity counts the output register, so memory never holds more than DEPTH-1.
  assign w_total = r_cnt + {{AW{1'b0}}, r_ovld};
  assign w_full  = (w_total == FULL_CNT);
  assign w_pop   = r_ovld & m_tready;
  assign w_wr    = r_byte_vld & (~w_full | w_pop);
  assign w_ld    = (~r_ovld | w_pop) & (r_cnt != '0);

  always_ff @(posedge clk_32M768) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_byte_user, r_byte_last, r_byte};
  end

  always_ff @(posedge clk_32M768 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_ovld     <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_byte_vld & ~w_wr;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_ld};
      if (~r_ovld | w_pop) begin
        if (r_cnt != '0) begin
          {r_tuser, r_tlast, r_tdata} <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_ovld   <= 1'b1;
        end else begin
          r_ovld <= 1'b0;
        end
      end
    end
  end

  assign m_tdata  = r_tdata;
  assign m_tvalid = r_ovld;
  assign m_tlast  = r_tlast;
  assign m_tuser  = r_tuser;
  assign lock     = (r_state == ST_PAYLOAD);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_rx_sync_deframer.sv
// Directed bench for rx_sync_deframer: a default instance plus a FIFO_DEPTH=4 instance
// share symbol stimulus; output bytes are queued on the falling edge and compared.
module tb_rx_sync_deframer;

  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sym_tvalid;
  logic [2:0] sym_tdata;
  logic [1:0] mode;
  logic [7:0] plen;
  logic       a_tready, b_tready;
  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, b_tvalid, a_tlast, b_tlast, a_tuser, b_tuser;
  logic       a_lock, b_lock, a_ovf, b_ovf;

  int n_vec = 0;
  int n_err = 0;
  int ovf_a = 0;
  int ovf_b = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  always #5 clk = ~clk;

  rx_sync_deframer u_dut (
    .clk_32M768(clk), .rst_32M768(rst_n), .sym_tvalid(sym_tvalid), .sym_tdata(sym_tdata),
    .MODE_CTRL(mode), .PAYLOAD_LEN(plen), .m_tdata(a_tdata), .m_tvalid(a_tvalid),
    .m_tready(a_tready), .m_tlast(a_tlast), .m_tuser(a_tuser), .lock(a_lock), .overflow(a_ovf)
  );

  rx_sync_deframer #(.FIFO_DEPTH(4)) u_dut4 (
    .clk_32M768(clk), .rst_32M768(rst_n), .sym_tvalid(sym_tvalid), .sym_tdata(sym_tdata),
    .MODE_CTRL(mode), .PAYLOAD_LEN(plen), .m_tdata(b_tdata), .m_tvalid(b_tvalid),
    .m_tready(b_tready), .m_tlast(b_tlast), .m_tuser(b_tuser), .lock(b_lock), .overflow(b_ovf)
  );

  always @(negedge clk) begin
    if (a_tvalid && a_tready) qa.push_back({a_tuser, a_tlast, a_tdata});
    if (b_tvalid && b_tready) qb.push_back({b_tuser, b_tlast, b_tdata});
    if (a_ovf) ovf_a++;
    if (b_ovf) ovf_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [2:0] s);
    sym_tdata  = s;
    sym_tvalid = 1'b1;
    tick(1);
    sym_tvalid = 1'b0;
    tick(1);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int k);
    logic [63:0] t;
    for (int i = n - k; i >= 0; i -= k) begin
      t = (v >> i) & ((64'd1 << k) - 64'd1);
      send_sym(t[2:0]);
    end
  endtask

  task automatic pop_chk(input string tag, input bit from_b, input logic [9:0] exp);
    logic [9:0] got;
    got = 10'h3FF;
    if (!from_b && qa.size() > 0) got = qa.pop_front();
    if (from_b && qb.size() > 0)  got = qb.pop_front();
    chk(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [31:0] w1;
    int          o0;

    rst_n = 1'b0; sym_tvalid = 1'b0; sym_tdata = '0; mode = 2'd0; plen = 8'd2;
    a_tready = 1'b1; b_tready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("rst_tvalid", 32'(a_tvalid), 0);
    chk("rst_tdata",  32'(a_tdata),  0);
    chk("rst_tlast",  32'(a_tlast),  0);
    chk("rst_tuser",  32'(a_tuser),  0);
    chk("rst_lock",   32'(a_lock),   0);
    chk("rst_ovf",    32'(a_ovf),    0);

    // BPSK normal frame with byte latency probe on the first byte
    send_bits(64'(SYNC), 32, 1);
    send_bits(64'h52, 7, 1);
    sym_tdata = 3'd1; sym_tvalid = 1'b1;
    tick(1);
    sym_tvalid = 1'b0;
    chk("t1_lock_on", 32'(a_lock), 1);
    tick(1);
    chk("t1_tvalid_e1", 32'(a_tvalid), 0);
    tick(1);
    chk("t1_tvalid_e2", 32'(a_tvalid), 1);
    chk("t1_tdata_e2",  32'(a_tdata),  32'hA5);
    chk("t1_tlast_e2",  32'(a_tlast),  0);
    send_bits(64'h3C, 8, 1);
    chk("t1_lock_off", 32'(a_lock), 0);
    tick(4);
    chk("t1_count", 32'(qa.size()), 2);
    pop_chk("t1_b0", 1'b0, 10'h0A5);
    pop_chk("t1_b1", 1'b0, 10'h13C);

    // BPSK inverted sync and payload
    send_bits(64'(~SYNC), 32, 1);
    send_bits(64'h5AC3, 16, 1);
    tick(6);
    chk("t2_count", 32'(qa.size()), 2);
    pop_chk("t2_b0", 1'b0, 10'h2A5);
    pop_chk("t2_b1", 1'b0, 10'h33C);

    // 8PSK: 33 sync bits (leading bit falls out of the register), 24 payload bits
    mode = 2'd2; plen = 8'd3;
    send_bits({32'h0, SYNC}, 33, 3);
    send_bits(64'h123456, 24, 3);
    tick(6);
    chk("t3_count", 32'(qa.size()), 3);
    pop_chk("t3_b0", 1'b0, 10'h012);
    pop_chk("t3_b1", 1'b0, 10'h034);
    pop_chk("t3_b2", 1'b0, 10'h156);
    chk("t3_lock", 32'(a_lock), 0);

    // Error tolerance: 2 errors rejected, 1 error accepted with lock timing
    mode = 2'd0; plen = 8'd1;
    send_bits(64'(SYNC ^ 32'h0001_0001), 32, 1);
    tick(4);
    chk("t4_lock_2err", 32'(a_lock), 0);
    w1 = SYNC ^ 32'h0000_0100;
    send_bits(64'(w1 >> 1), 31, 1);
    sym_tdata = {2'b00, w1[0]}; sym_tvalid = 1'b1;
    tick(1);
    sym_tvalid = 1'b0;
    chk("t4_lock_e0", 32'(a_lock), 0);
    tick(1);
    chk("t4_lock_e1", 32'(a_lock), 1);
    tick(1);
    send_bits(64'h77, 8, 1);
    tick(6);
    chk("t4_count", 32'(qa.size()), 1);
    pop_chk("t4_b0", 1'b0, 10'h177);

    // Overflow on the 4-deep instance, then full-rate drain
    plen = 8'd6; b_tready = 1'b0;
    qb.delete();
    o0 = ovf_b;
    send_bits(64'(SYNC), 32, 1);
    send_bits(64'h112233445566, 48, 1);
    tick(6);
    chk("t5_ovf_b", 32'(ovf_b - o0), 2);
    chk("t5_ovf_a", 32'(ovf_a), 0);
    chk("t5_hold_valid", 32'(b_tvalid), 1);
    chk("t5_hold_data",  32'(b_tdata),  32'h11);
    chk("t5_hold_last",  32'(b_tlast),  0);
    b_tready = 1'b1;
    tick(4);
    chk("t5_drained", 32'(b_tvalid), 0);
    chk("t5_b_count", 32'(qb.size()), 4);
    pop_chk("t5_d0", 1'b1, 10'h011);
    pop_chk("t5_d1", 1'b1, 10'h022);
    pop_chk("t5_d2", 1'b1, 10'h033);
    pop_chk("t5_d3", 1'b1, 10'h044);
    chk("t5_a_count", 32'(qa.size()), 6);
    repeat (5) void'(qa.pop_front());
    pop_chk("t5_a_last", 1'b0, 10'h166);

    // Reset mid-frame, then a clean frame
    plen = 8'd5; a_tready = 1'b0;
    qa.delete();
    send_bits(64'(SYNC), 32, 1);
    send_bits(64'hABCDEF, 24, 1);
    tick(4);
    chk("t6_pre_valid", 32'(a_tvalid), 1);
    chk("t6_pre_lock",  32'(a_lock),   1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(a_tvalid), 0);
    chk("t6_rst_lock",  32'(a_lock),   0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    a_tready = 1'b1; plen = 8'd2;
    send_bits(64'(SYNC), 32, 1);
    send_bits(64'hC35A, 16, 1);
    tick(6);
    chk("t6_count", 32'(qa.size()), 2);
    pop_chk("t6_b0", 1'b0, 10'h0C3);
    pop_chk("t6_b1", 1'b0, 10'h15A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
